// File: rtl/pipe_stall_ctrl.sv
// Hazard/flow controller for the five-stage pipeline: per-register stall codes,
// squashed-fetch tracking after a redirect, and stall/redirect counters.
module pipe_stall_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic             if_ready,
  input  logic             me_mem_req,
  input  logic             me_mem_ready,
  input  logic             me_redirect,
  input  logic             load_use,
  output logic [1:0]       pc_stall,
  output logic [1:0]       if_id_stall,
  output logic [1:0]       id_ex_stall,
  output logic [1:0]       ex_me_stall,
  output logic [1:0]       me_wb_stall,
  output logic             if_ack,
  output logic             drop_pending,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [1:0] STALL_NEXT = 2'b00;
  localparam logic [1:0] STALL_KEEP = 2'b01;
  localparam logic [1:0] STALL_ZERO = 2'b10;

  typedef enum logic {RUN, DROP} state_t;

  state_t state, state_nxt;
  logic   mem_busy;
  logic   fetch_ok;
  logic   redirect_acc;

  assign mem_busy     = me_mem_req & ~me_mem_ready;
  assign fetch_ok     = if_ready & (state == RUN);
  assign drop_pending = (state == DROP);

  always_comb begin
    pc_stall     = STALL_NEXT;
    if_id_stall  = STALL_NEXT;
    id_ex_stall  = STALL_NEXT;
    ex_me_stall  = STALL_NEXT;
    me_wb_stall  = STALL_NEXT;
    if_ack       = 1'b1;
    redirect_acc = 1'b0;
    if (rst) begin
      pc_stall    = STALL_KEEP;
      if_id_stall = STALL_ZERO;
      id_ex_stall = STALL_ZERO;
      ex_me_stall = STALL_ZERO;
      me_wb_stall = STALL_ZERO;
      if_ack      = 1'b0;
    end else if (mem_busy) begin
      pc_stall    = STALL_KEEP;
      if_id_stall = STALL_KEEP;
      id_ex_stall = STALL_KEEP;
      ex_me_stall = STALL_KEEP;
      me_wb_stall = STALL_ZERO;
      // a squashed response can still be discarded while memory stalls
      if_ack      = (state == DROP) & if_ready;
    end else if (me_redirect) begin
      if_id_stall  = STALL_ZERO;
      id_ex_stall  = STALL_ZERO;
      ex_me_stall  = STALL_ZERO;
      if_ack       = if_ready;
      redirect_acc = 1'b1;
    end else if (state == DROP) begin
      pc_stall    = STALL_KEEP;
      if_id_stall = STALL_ZERO;
      if_ack      = if_ready;
    end else if (load_use) begin
      pc_stall    = STALL_KEEP;
      if_id_stall = STALL_KEEP;
      id_ex_stall = STALL_ZERO;
      if_ack      = 1'b0;
    end else if (!fetch_ok) begin
      pc_stall    = STALL_KEEP;
      if_id_stall = STALL_ZERO;
      if_ack      = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == DROP) begin
      if (if_ready) state_nxt = RUN;
    end else if (redirect_acc && if_req && !if_ready) begin
      state_nxt = DROP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      stall_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (pc_stall != STALL_NEXT) stall_cnt <= stall_cnt + 1'b1;
      if (redirect_acc) redirect_cnt <= redirect_cnt + 1'b1;
    end
  end

endmodule
